interp_seq_multiplier: RTL and testbench

//  Sequential signed fixed-point multiplier: the responder on the start_mul / multipiler_done

---
 rtl/interp_seq_multiplier_pkg.sv | 13 +
 rtl/interp_seq_multiplier_mul_sat.sv | 34 +++
 rtl/interp_seq_multiplier.sv | 120 ++++++++++++
 tb/tb_interp_seq_multiplier.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/interp_seq_multiplier_pkg.sv
// Shared fixed-point defaults and multiplier state codes for the interpolation datapath.
package interp_seq_multiplier_pkg;

  localparam int IMUL_WIDTH = 16;
  localparam int IMUL_FRAC  = 8;

  typedef enum logic [1:0] {
    IMUL_IDLE   = 2'd0,
    IMUL_RUN    = 2'd1,
    IMUL_FINISH = 2'd2
  } imul_state_e;

endpackage

// File: rtl/interp_seq_multiplier_mul_sat.sv
// Combinational saturation: unsigned magnitude plus sign -> clamped two's complement result.
// Shared with the divider, so it knows nothing about how the magnitude was produced.
module interp_seq_multiplier_mul_sat
  import interp_seq_multiplier_pkg::*;
#(
  parameter int WIDTH = IMUL_WIDTH
) (
  input  logic [2*WIDTH-1:0] mag_i,
  input  logic               sign_i,
  output logic [WIDTH-1:0]   product_o,
  output logic               overflow_o
);

  localparam logic [2*WIDTH-1:0] POS_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [2*WIDTH-1:0] NEG_MAX = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  always_comb begin
    product_o  = mag_i[WIDTH-1:0];
    overflow_o = 1'b0;
    if (sign_i) begin
      // Magnitude of exactly 2^(WIDTH-1) negates cleanly to the most negative code.
      if (mag_i > NEG_MAX) begin
        product_o  = {1'b1, {(WIDTH-1){1'b0}}};
        overflow_o = 1'b1;
      end else begin
        product_o  = -mag_i[WIDTH-1:0];
      end
    end else if (mag_i > POS_MAX) begin
      product_o  = {1'b0, {(WIDTH-1){1'b1}}};
      overflow_o = 1'b1;
    end
  end

endmodule

// File: rtl/interp_seq_multiplier.sv
// Sequential signed fixed-point multiplier: radix-2 shift-add on magnitudes, WIDTH+1 cycles,
// saturated result and overflow held until the next completion.
module interp_seq_multiplier
  import interp_seq_multiplier_pkg::*;
#(
  parameter int WIDTH = IMUL_WIDTH,
  parameter int FRAC  = IMUL_FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] product,
  output logic             done,
  output logic             overflow,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int AW = 2 * WIDTH;

  imul_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] ma_q, ma_d;
  logic [WIDTH-1:0] mb_q, mb_d;
  logic             sign_q, sign_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;

  logic [AW-1:0]    mag;
  logic [WIDTH-1:0] sat_product;
  logic             sat_overflow;

  assign mag = acc_q >> FRAC;

  interp_seq_multiplier_mul_sat #(
    .WIDTH (WIDTH)
  ) u_mul_sat (
    .mag_i      (mag),
    .sign_i     (sign_q),
    .product_o  (sat_product),
    .overflow_o (sat_overflow)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ma_d       = ma_q;
    mb_d       = mb_q;
    sign_d     = sign_q;
    acc_d      = acc_q;
    product_d  = product_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    case (state_q)
      IMUL_IDLE: begin
        if (start) begin
          state_d = IMUL_RUN;
          // Unsigned WIDTH-bit magnitude so that |-2^(WIDTH-1)| still fits.
          ma_d    = op_a[WIDTH-1] ? -op_a : op_a;
          mb_d    = op_b[WIDTH-1] ? -op_b : op_b;
          sign_d  = op_a[WIDTH-1] ^ op_b[WIDTH-1];
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      IMUL_RUN: begin
        if (mb_q[cnt_q]) begin
          acc_d = acc_q + ({{WIDTH{1'b0}}, ma_q} << cnt_q);
        end
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = IMUL_FINISH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      IMUL_FINISH: begin
        product_d  = sat_product;
        overflow_d = sat_overflow;
        done_d     = 1'b1;
        state_d    = IMUL_IDLE;
      end
      default: state_d = IMUL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IMUL_IDLE;
      cnt_q      <= '0;
      ma_q       <= '0;
      mb_q       <= '0;
      sign_q     <= 1'b0;
      acc_q      <= '0;
      product_q  <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ma_q       <= ma_d;
      mb_q       <= mb_d;
      sign_q     <= sign_d;
      acc_q      <= acc_d;
      product_q  <= product_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign product  = product_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != IMUL_IDLE) | done_q;

endmodule

// File: tb/tb_interp_seq_multiplier.sv
// Directed and random checks of the sequential multiplier against a scoreboard of expected results.
module tb_interp_seq_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [15:0] product;
  logic        done;
  logic        overflow;
  logic        busy;

  int checks;
  int errors;
  logic [16:0] sb_q[$];

  interp_seq_multiplier #(
    .WIDTH (16),
    .FRAC  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .product  (product),
    .done     (done),
    .overflow (overflow),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full signed product, truncate the magnitude, then clamp.
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b);
    longint p;
    longint m;
    p = longint'($signed(a)) * longint'($signed(b));
    m = ((p < 0) ? -p : p) >> 8;
    if (p < 0) begin
      if (m > 32768) return {1'b1, 16'h8000};
      return {1'b0, 16'(-m)};
    end
    if (m > 32767) return {1'b1, 16'h7FFF};
    return {1'b0, 16'(m)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_compare(input string tag);
    logic [16:0] exp;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp = sb_q.pop_front();
      check({tag, "_product"}, {16'd0, product}, {16'd0, exp[15:0]});
      check({tag, "_overflow"}, {31'd0, overflow}, {31'd0, exp[16]});
    end
  endtask

  // Drive one start pulse at the next edge and queue the expected result.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [16:0] exp);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    sb_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called just after the accepting edge; p1/p2 are edge offsets at which to pulse a stray start.
  task automatic wait_done(input string tag, input int p1, input int p2, input bit hold,
                           output int lat);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      if (k == p1 - 1 || k == p2 - 1) begin
        start = 1'b1;
        op_a  = 16'h7FFF;
        op_b  = 16'h7FFF;
      end else begin
        start = hold;
      end
      @(negedge clk);
      k++;
    end
    lat = k;
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd1);
    pop_compare(tag);
  endtask

  task automatic single(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [16:0] exp);
    int lat;
    issue(a, b, exp);
    wait_done(tag, -9, -9, 1'b0, lat);
    check({tag, "_latency"}, lat, 32'd17);
    @(negedge clk);
    check({tag, "_done_width"}, {31'd0, done}, 32'd0);
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [15:0] ra;
    logic [15:0] rb;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    op_a   = '0;
    op_b   = '0;
    repeat (3) @(negedge clk);
    check("rst_product", {16'd0, product}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic positive product with latency and busy tracking
    issue(16'h0180, 16'h0200, {1'b0, 16'h0300});
    check("t1_busy_start", {31'd0, busy}, 32'd1);
    wait_done("t1", -9, -9, 1'b0, lat);
    check("t1_latency", lat, 32'd17);
    @(negedge clk);
    check("t1_done_width", {31'd0, done}, 32'd0);
    check("t1_busy_after", {31'd0, busy}, 32'd0);

    single("t2_neg", 16'hFE80, 16'h0200, {1'b0, 16'hFD00});
    single("t2_min", 16'h8000, 16'h0100, {1'b0, 16'h8000});

    // Stray starts mid-run and on the finishing edge are dropped
    issue(16'h0180, 16'h0200, {1'b0, 16'h0300});
    wait_done("t4", 3, 17, 1'b0, lat);
    check("t4_latency", lat, 32'd17);
    start = 1'b0;
    @(negedge clk);
    check("t4_done_width", {31'd0, done}, 32'd0);
    check("t4_no_requeue", {31'd0, busy}, 32'd0);

    single("t3_pos_sat", 16'h7F00, 16'h0200, {1'b1, 16'h7FFF});
    single("t3_negneg_sat", 16'h8000, 16'hFF00, {1'b1, 16'h7FFF});

    // Reset in the middle of a run aborts it silently
    start = 1'b1;
    op_a  = 16'h0180;
    op_b  = 16'h0200;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_done", {31'd0, done}, 32'd0);
    check("t5_product", {16'd0, product}, 32'd0);
    check("t5_overflow", {31'd0, overflow}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("t5_no_done", pulses, 32'd0);
    single("t5_after", 16'hFF00, 16'hFF00, {1'b0, 16'h0100});

    single("zero_neg", 16'h0000, 16'h8000, {1'b0, 16'h0000});
    single("tiny_neg", 16'hFFFF, 16'h0001, {1'b0, 16'h0000});

    // Start held high: back-to-back operations against the reference model
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 7))
        0: ra = 16'h8000;
        1: ra = 16'h0000;
        2: ra = 16'h7FFF;
        default: ra = 16'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0: rb = 16'h8000;
        1: rb = 16'hFF00;
        2: rb = 16'h0100;
        default: rb = 16'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 16'h03FF));
      endcase
      start = 1'b1;
      op_a  = ra;
      op_b  = rb;
      sb_q.push_back(model(ra, rb));
      @(negedge clk);
      wait_done("t6", -9, -9, 1'b1, lat);
      check("t6_period", lat + 1, 32'd18);
    end
    start = 1'b0;
    @(negedge clk);
    check("t6_sb_drained", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
